// File: rtl/ddma_pkg.sv
// Shared types for the DMA engine: send/receive FSM state codes and the receive
// buffer base address.
package ddma_pkg;

   typedef enum logic [2:0] {
      StSendIdle    = 3'd0,
      StSendHdr     = 3'd1,
      StSendSize    = 3'd2,
      StSendPayload = 3'd3,
      StSendDone    = 3'd4
   } send_state_e;

   typedef enum logic [2:0] {
      StRecvIdle    = 3'd0,
      StRecvSize    = 3'd2,
      StRecvPayload = 3'd3,
      StRecvWaitAck = 3'd4
   } recv_state_e;

   localparam logic [31:0] RECV_BASE = 32'h0;
   localparam logic [3:0]  WB_WORD   = 4'hF;
   localparam logic [3:0]  WB_READ   = 4'h0;

endpackage

// File: rtl/ddma_arbiter.sv
// Memory-port arbiter: receive wins when contention starts, then ownership
// flips every INTERLEAVING_GRAIN cycles while both engines keep requesting.
module ddma_arbiter #(
   parameter int unsigned INTERLEAVING_GRAIN = 3
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_req_send,
   input  logic i_req_recv,
   output logic o_grant_send,
   output logic o_grant_recv
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] LAST_CNT =
      (INTERLEAVING_GRAIN > 1) ? CNT_W'(INTERLEAVING_GRAIN - 1) : '0;

   logic             r_owner_recv;
   logic [CNT_W-1:0] r_cnt;
   logic             w_both;

   assign w_both       = i_req_send & i_req_recv;
   assign o_grant_recv = i_req_recv & (~i_req_send | r_owner_recv);
   assign o_grant_send = i_req_send & (~i_req_recv | ~r_owner_recv);

   // Any break in contention hands the next contended cycle back to receive.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_owner_recv <= 1'b1;
         r_cnt        <= '0;
      end else if (!w_both) begin
         r_owner_recv <= 1'b1;
         r_cnt        <= '0;
      end else if (r_cnt == LAST_CNT) begin
         r_owner_recv <= ~r_owner_recv;
         r_cnt        <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ddma_engine.sv
// DMA engine between a single-port RAM and a router port: sends a RAM block as a
// packet and concurrently stores an incoming packet at RECV_BASE.
module ddma_engine
   import ddma_pkg::*;
#(
   parameter int unsigned MEMORY_WIDTH       = 32,
   parameter int unsigned FLIT_WIDTH         = 32,
   parameter int unsigned INTERLEAVING_GRAIN = 3,
   parameter int unsigned ADDRESS            = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [31:0]             dest_in,
   input  logic [31:0]             addr_in,
   input  logic [31:0]             size_in,
   input  logic                    cmd_in,
   output logic                    irq_send_out,
   output logic                    irq_recv_out,
   output logic [2:0]              state_send_out,
   output logic [2:0]              state_recv_out,
   output logic                    mem_enable_out,
   output logic [MEMORY_WIDTH-1:0] mem_addr_out,
   output logic [MEMORY_WIDTH-1:0] mem_data_out,
   output logic [3:0]              mem_wb_out,
   input  logic [MEMORY_WIDTH-1:0] mem_data_in,
   input  logic                    rx_in,
   input  logic [FLIT_WIDTH-1:0]   rx_data_in,
   output logic                    rx_credit_out,
   output logic                    tx_out,
   output logic [FLIT_WIDTH-1:0]   tx_data_out,
   input  logic                    tx_credit_in,
   output logic                    tx_clock_out
);

   localparam logic [15:0]             SRC_ADDR  = 16'(ADDRESS);
   localparam logic [MEMORY_WIDTH-1:0] WORD_STEP = MEMORY_WIDTH'(4);

   send_state_e             r_send_state;
   recv_state_e             r_recv_state;
   logic                    r_cmd_q;
   logic [31:0]             r_dest;
   logic [31:0]             r_size;
   logic [MEMORY_WIDTH-1:0] r_rd_addr;
   logic [31:0]             r_rd_cnt;
   logic [31:0]             r_tx_cnt;
   logic                    r_rd_pend;
   logic [FLIT_WIDTH-1:0]   r_buf;
   logic                    r_buf_valid;
   logic                    r_irq_send;
   logic [MEMORY_WIDTH-1:0] r_wr_addr;
   logic [15:0]             r_rx_size;
   logic [15:0]             r_rx_cnt;
   logic                    r_irq_recv;

   logic                    w_cmd_rise;
   logic                    w_req_send;
   logic                    w_req_recv;
   logic                    w_grant_send;
   logic                    w_grant_recv;
   logic                    w_tx_valid;
   logic                    w_tx_fire;
   logic                    w_rx_fire;
   logic                    w_rd_issue;
   logic [FLIT_WIDTH-1:0]   w_tx_data;

   assign w_cmd_rise = cmd_in & ~r_cmd_q;

   assign w_req_send = (r_send_state == StSendHdr) || (r_send_state == StSendSize) ||
                       (r_send_state == StSendPayload);
   assign w_req_recv = rx_in && (r_recv_state != StRecvWaitAck);

   ddma_arbiter #(
      .INTERLEAVING_GRAIN (INTERLEAVING_GRAIN)
   ) u_arbiter (
      .i_clk        (clock),
      .i_reset      (reset),
      .i_req_send   (w_req_send),
      .i_req_recv   (w_req_recv),
      .o_grant_send (w_grant_send),
      .o_grant_recv (w_grant_recv)
   );

   assign w_tx_valid = (r_send_state == StSendHdr) || (r_send_state == StSendSize) ||
                       ((r_send_state == StSendPayload) && r_buf_valid);
   assign tx_out     = w_tx_valid & w_grant_send;
   assign w_tx_fire  = tx_out & tx_credit_in;

   // One-word prefetch: a read is only issued when its data has a free slot
   // waiting for it, so backpressure never overwrites an unsent word.
   assign w_rd_issue = (r_send_state == StSendPayload) && w_grant_send &&
                       (r_rd_cnt != r_size) && !r_rd_pend && (!r_buf_valid || w_tx_fire);

   assign rx_credit_out = (r_recv_state != StRecvWaitAck) & w_grant_recv;
   assign w_rx_fire     = rx_in & rx_credit_out;

   always_comb begin
      w_tx_data = '0;
      case (r_send_state)
         StSendHdr:     w_tx_data = FLIT_WIDTH'(r_dest);
         StSendSize:    w_tx_data = FLIT_WIDTH'({SRC_ADDR, r_size[15:0]});
         StSendPayload: w_tx_data = r_buf;
         default:       w_tx_data = '0;
      endcase
   end

   assign tx_data_out = w_tx_data;

   always_comb begin
      mem_enable_out = 1'b0;
      mem_addr_out   = '0;
      mem_data_out   = '0;
      mem_wb_out     = WB_READ;
      if (w_rx_fire) begin
         mem_enable_out = 1'b1;
         mem_addr_out   = r_wr_addr;
         mem_data_out   = MEMORY_WIDTH'(rx_data_in);
         mem_wb_out     = WB_WORD;
      end else if (w_rd_issue) begin
         mem_enable_out = 1'b1;
         mem_addr_out   = r_rd_addr;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cmd_q <= 1'b0;
      end else begin
         r_cmd_q <= cmd_in;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_send_state <= StSendIdle;
         r_dest       <= '0;
         r_size       <= '0;
         r_rd_addr    <= '0;
         r_rd_cnt     <= '0;
         r_tx_cnt     <= '0;
         r_rd_pend    <= 1'b0;
         r_buf        <= '0;
         r_buf_valid  <= 1'b0;
         r_irq_send   <= 1'b0;
      end else begin
         r_rd_pend <= w_rd_issue;
         if (r_rd_pend) begin
            r_buf       <= FLIT_WIDTH'(mem_data_in);
            r_buf_valid <= 1'b1;
         end else if (w_tx_fire && (r_send_state == StSendPayload)) begin
            r_buf_valid <= 1'b0;
         end
         if (w_rd_issue) begin
            r_rd_addr <= r_rd_addr + WORD_STEP;
            r_rd_cnt  <= r_rd_cnt + 32'd1;
         end
         case (r_send_state)
            StSendIdle: begin
               if (w_cmd_rise && (size_in != 32'd0)) begin
                  r_dest       <= dest_in;
                  r_size       <= size_in;
                  r_rd_addr    <= MEMORY_WIDTH'(addr_in);
                  r_rd_cnt     <= '0;
                  r_tx_cnt     <= '0;
                  r_buf_valid  <= 1'b0;
                  r_send_state <= StSendHdr;
               end
            end
            StSendHdr: begin
               if (w_tx_fire) r_send_state <= StSendSize;
            end
            StSendSize: begin
               if (w_tx_fire) r_send_state <= StSendPayload;
            end
            StSendPayload: begin
               if (w_tx_fire) begin
                  r_tx_cnt <= r_tx_cnt + 32'd1;
                  if (r_tx_cnt == r_size - 32'd1) begin
                     r_send_state <= StSendDone;
                     r_irq_send   <= 1'b1;
                  end
               end
            end
            StSendDone: begin
               if (w_cmd_rise) begin
                  r_irq_send   <= 1'b0;
                  r_send_state <= StSendIdle;
               end
            end
            default: r_send_state <= StSendIdle;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_recv_state <= StRecvIdle;
         r_wr_addr    <= MEMORY_WIDTH'(RECV_BASE);
         r_rx_size    <= '0;
         r_rx_cnt     <= '0;
         r_irq_recv   <= 1'b0;
      end else begin
         if (w_rx_fire) r_wr_addr <= r_wr_addr + WORD_STEP;
         case (r_recv_state)
            StRecvIdle: begin
               if (w_rx_fire) r_recv_state <= StRecvSize;
            end
            StRecvSize: begin
               if (w_rx_fire) begin
                  r_rx_size <= rx_data_in[15:0];
                  r_rx_cnt  <= '0;
                  if (rx_data_in[15:0] == 16'd0) begin
                     r_recv_state <= StRecvWaitAck;
                     r_irq_recv   <= 1'b1;
                  end else begin
                     r_recv_state <= StRecvPayload;
                  end
               end
            end
            StRecvPayload: begin
               if (w_rx_fire) begin
                  r_rx_cnt <= r_rx_cnt + 16'd1;
                  if (r_rx_cnt == r_rx_size - 16'd1) begin
                     r_recv_state <= StRecvWaitAck;
                     r_irq_recv   <= 1'b1;
                  end
               end
            end
            StRecvWaitAck: begin
               // A zero-size command is the receive acknowledge.
               if (w_cmd_rise && (size_in == 32'd0)) begin
                  r_irq_recv   <= 1'b0;
                  r_wr_addr    <= MEMORY_WIDTH'(RECV_BASE);
                  r_recv_state <= StRecvIdle;
               end
            end
            default: r_recv_state <= StRecvIdle;
         endcase
      end
   end

   assign irq_send_out   = r_irq_send;
   assign irq_recv_out   = r_irq_recv;
   assign state_send_out = r_send_state;
   assign state_recv_out = r_recv_state;
   assign tx_clock_out   = clock;

endmodule

// File: tb/tb_ddma_engine.sv
// Directed self-checking bench for ddma_engine: send, backpressure, receive,
// zero-size receive, concurrent send/receive with grant interleaving, reset.
module tb_ddma_engine;

   localparam int unsigned SRC = 7;
   localparam logic [31:0] SEND_BASE = 32'h4000_0100;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] dest_in, addr_in, size_in;
   logic        cmd_in;
   logic        irq_send_out, irq_recv_out;
   logic [2:0]  state_send_out, state_recv_out;
   logic        mem_enable_out;
   logic [31:0] mem_addr_out, mem_data_out;
   logic [3:0]  mem_wb_out;
   logic [31:0] mem_data_in;
   logic        rx_in;
   logic [31:0] rx_data_in;
   logic        rx_credit_out;
   logic        tx_out;
   logic [31:0] tx_data_out;
   logic        tx_credit_in;
   logic        tx_clock_out;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   ddma_engine #(
      .MEMORY_WIDTH       (32),
      .FLIT_WIDTH         (32),
      .INTERLEAVING_GRAIN (3),
      .ADDRESS            (SRC)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .dest_in        (dest_in),
      .addr_in        (addr_in),
      .size_in        (size_in),
      .cmd_in         (cmd_in),
      .irq_send_out   (irq_send_out),
      .irq_recv_out   (irq_recv_out),
      .state_send_out (state_send_out),
      .state_recv_out (state_recv_out),
      .mem_enable_out (mem_enable_out),
      .mem_addr_out   (mem_addr_out),
      .mem_data_out   (mem_data_out),
      .mem_wb_out     (mem_wb_out),
      .mem_data_in    (mem_data_in),
      .rx_in          (rx_in),
      .rx_data_in     (rx_data_in),
      .rx_credit_out  (rx_credit_out),
      .tx_out         (tx_out),
      .tx_data_out    (tx_data_out),
      .tx_credit_in   (tx_credit_in),
      .tx_clock_out   (tx_clock_out)
   );

   // Single-port RAM with one cycle read latency.
   logic [31:0] mem [logic [31:0]];
   always @(posedge clock) begin
      if (mem_enable_out) begin
         if (mem_wb_out == 4'hF) mem[mem_addr_out] = mem_data_out;
         else mem_data_in <= mem.exists(mem_addr_out) ? mem[mem_addr_out] : 32'h0;
      end
   end

   logic [31:0] tx_q[$];
   always @(negedge clock) begin
      if (!reset && tx_out && tx_credit_in) tx_q.push_back(tx_data_out);
   end

   logic [31:0] rx_q[$];
   logic        rx_take = 1'b0;
   always @(negedge clock) rx_take = !reset && rx_in && rx_credit_out;
   always @(posedge clock) begin
      #1;
      if (rx_take && rx_q.size() != 0) void'(rx_q.pop_front());
      rx_take    = 1'b0;
      rx_in      = (rx_q.size() != 0);
      rx_data_in = (rx_q.size() != 0) ? rx_q[0] : 32'h0;
   end

   // Who held the port on each cycle where both engines wanted it.
   logic rec_hist = 1'b0;
   int   hist[$];
   always @(negedge clock) begin
      if (rec_hist && !reset && (state_send_out inside {3'd1, 3'd2, 3'd3}) && rx_in &&
          (state_recv_out != 3'd4))
         hist.push_back(int'(rx_credit_out));
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed running expected done");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_send(input logic [2:0] code, input string tag);
      for (int i = 0; i < 2000 && state_send_out != code; i++) @(negedge clock);
      check(tag, 32'(state_send_out), 32'(code));
   endtask

   task automatic wait_recv(input logic [2:0] code, input string tag);
      for (int i = 0; i < 2000 && state_recv_out != code; i++) @(negedge clock);
      check(tag, 32'(state_recv_out), 32'(code));
   endtask

   task automatic cmd(input logic [31:0] d, input logic [31:0] a, input logic [31:0] s);
      @(posedge clock); #1;
      dest_in = d; addr_in = a; size_in = s; cmd_in = 1'b1;
      @(posedge clock); #1;
      cmd_in = 1'b0;
   endtask

   function automatic logic [31:0] ram(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] txw(input int i);
      return (i < tx_q.size()) ? tx_q[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] pay(input int i);
      return 32'hC0DE_0000 + 32'(i);
   endfunction

   task automatic check_send(input string tag, input logic [31:0] d, input int n);
      check({tag, "_count"}, 32'(tx_q.size()), 32'(n + 2));
      check({tag, "_hdr"}, txw(0), d);
      check({tag, "_size"}, txw(1), {16'(SRC), 16'(n)});
      for (int i = 0; i < n; i++) check({tag, "_payload"}, txw(i + 2), pay(i));
   endtask

   initial begin
      reset = 1'b1; cmd_in = 1'b0; dest_in = '0; addr_in = '0; size_in = '0;
      tx_credit_in = 1'b1;
      for (int i = 0; i < 16; i++) mem[SEND_BASE + 32'(4 * i)] = pay(i);
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst_state_send", 32'(state_send_out), 32'd0);
      check("rst_state_recv", 32'(state_recv_out), 32'd0);
      check("rst_irq_send", 32'(irq_send_out), 32'd0);
      check("rst_irq_recv", 32'(irq_recv_out), 32'd0);
      check("rst_tx_out", 32'(tx_out), 32'd0);
      check("rst_rx_credit", 32'(rx_credit_out), 32'd0);
      check("rst_mem_enable", 32'(mem_enable_out), 32'd0);
      check("rst_mem_wb", 32'(mem_wb_out), 32'd0);

      // Plain send of three words
      tx_q.delete();
      cmd(32'h0101, SEND_BASE, 32'd3);
      check("send_hdr_state", 32'(state_send_out), 32'd1);
      wait_send(3'd4, "send_done_state");
      check("send_irq", 32'(irq_send_out), 32'd1);
      check_send("send", 32'h0101, 3);
      cmd(32'h0, 32'h0, 32'd1);
      check("send_ack_irq", 32'(irq_send_out), 32'd0);
      check("send_ack_state", 32'(state_send_out), 32'd0);

      // Backpressure in PAYLOAD
      tx_q.delete();
      cmd(32'h0101, SEND_BASE, 32'd3);
      wait_send(3'd3, "bp_payload_state");
      @(posedge clock); #1 tx_credit_in = 1'b0;
      for (int i = 0; i < 50 && !tx_out; i++) @(negedge clock);
      check("bp_tx_valid", 32'(tx_out), 32'd1);
      check("bp_first_word", tx_data_out, pay(0));
      repeat (5) begin
         @(negedge clock);
         check("bp_hold_valid", 32'(tx_out), 32'd1);
         check("bp_hold_data", tx_data_out, pay(0));
      end
      @(posedge clock); #1 tx_credit_in = 1'b1;
      wait_send(3'd4, "bp_done_state");
      check_send("bp", 32'h0101, 3);
      cmd(32'h0, 32'h0, 32'd1);

      // Receive of two words
      rx_q.push_back(32'h0000_0000);
      rx_q.push_back(32'h0000_0002);
      rx_q.push_back(32'h1234_5678);
      rx_q.push_back(32'h9ABC_DEF0);
      wait_recv(3'd4, "rx_wait_ack_state");
      check("rx_irq", 32'(irq_recv_out), 32'd1);
      check("rx_credit_wait", 32'(rx_credit_out), 32'd0);
      check("rx_ram0", ram(32'h0), 32'h0000_0000);
      check("rx_ram1", ram(32'h4), 32'h0000_0002);
      check("rx_ram2", ram(32'h8), 32'h1234_5678);
      check("rx_ram3", ram(32'hC), 32'h9ABC_DEF0);
      cmd(32'h0, 32'h0, 32'd0);
      check("rx_ack_irq", 32'(irq_recv_out), 32'd0);
      check("rx_ack_state", 32'(state_recv_out), 32'd0);

      // Zero-size packet stores only the header words
      rx_q.push_back(32'h0000_0005);
      rx_q.push_back(32'h0009_0000);
      wait_recv(3'd4, "rx0_wait_ack_state");
      check("rx0_irq", 32'(irq_recv_out), 32'd1);
      check("rx0_ram0", ram(32'h0), 32'h0000_0005);
      check("rx0_ram1", ram(32'h4), 32'h0009_0000);
      check("rx0_ram2_kept", ram(32'h8), 32'h1234_5678);
      cmd(32'h0, 32'h0, 32'd0);
      check("rx0_ack_state", 32'(state_recv_out), 32'd0);

      // Concurrent 16-word send and receive
      tx_q.delete();
      hist.delete();
      rec_hist = 1'b1;
      rx_q.push_back(32'h0000_0101);
      rx_q.push_back(32'h0000_0010);
      for (int i = 0; i < 16; i++) rx_q.push_back(32'h5EED_0000 + 32'(i));
      cmd(32'h0202, SEND_BASE, 32'd16);
      wait_recv(3'd4, "cc_recv_state");
      wait_send(3'd4, "cc_send_state");
      rec_hist = 1'b0;
      check_send("cc_send", 32'h0202, 16);
      check("cc_rx_hdr", ram(32'h0), 32'h0000_0101);
      check("cc_rx_size", ram(32'h4), 32'h0000_0010);
      for (int i = 0; i < 16; i++)
         check("cc_rx_payload", ram(32'(8 + 4 * i)), 32'h5EED_0000 + 32'(i));
      check("cc_hist_len", 32'(hist.size() >= 12), 32'd1);
      for (int i = 0; i < 12; i++)
         check("cc_grant", (i < hist.size()) ? 32'(hist[i]) : 32'hDEAD_BEEF,
               ((i / 3) % 2 == 0) ? 32'd1 : 32'd0);
      cmd(32'h0, 32'h0, 32'd0);
      check("cc_ack_send", 32'(state_send_out), 32'd0);
      check("cc_ack_recv", 32'(state_recv_out), 32'd0);

      // Reset during PAYLOAD, then a clean send
      cmd(32'h0303, SEND_BASE, 32'd16);
      wait_send(3'd3, "rst_mid_payload");
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      check("rst_mid_state_send", 32'(state_send_out), 32'd0);
      check("rst_mid_state_recv", 32'(state_recv_out), 32'd0);
      check("rst_mid_tx_out", 32'(tx_out), 32'd0);
      tx_q.delete();
      cmd(32'h0101, SEND_BASE, 32'd3);
      wait_send(3'd4, "post_rst_done");
      check_send("post_rst", 32'h0101, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
